// File: rtl/caravel_spiflash_pkg.sv
// Shared types and constants for the Caravel SPI flash read controller.
// Holds the controller state encoding, flash opcodes and the byte-order helper.
package caravel_spiflash_pkg;

    typedef enum logic [2:0] {
        ST_WAKE = 3'd0,
        ST_GAP  = 3'd1,
        ST_IDLE = 3'd2,
        ST_CMD  = 3'd3,
        ST_ADDR = 3'd4,
        ST_DATA = 3'd5,
        ST_ACK  = 3'd6
    } state_t;

    localparam logic [7:0] CMD_WAKE = 8'hAB;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [2:0] GAP_LEN  = 3'd4;

    // The first byte on the wire lands in the least significant byte lane.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/caravel_spiflash_spi_shifter.sv
// SPI mode-0 shift engine: clock divider, MSB-first shift-out on falling edges,
// shift-in on rising edges. A new start on the done cycle chains frames seamlessly.
module spi_shifter #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  len,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        done,
    output logic [31:0] rx_data
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_r;
    logic [5:0]    bits_r;
    logic [31:0]   tx_r;
    logic [31:0]   rx_r;
    logic          sclk_r;
    logic          busy_r;
    logic          tick_s;

    assign tick_s  = busy_r && (div_r == DW'(CLK_DIV - 1));
    assign done    = tick_s && sclk_r && (bits_r == 6'd1);
    assign sclk    = sclk_r;
    assign mosi    = tx_r[31];
    assign rx_data = rx_r;

    // Divider, bit counter and both shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r  <= '0;
            bits_r <= 6'd0;
            tx_r   <= 32'h0000_0000;
            rx_r   <= 32'h0000_0000;
            sclk_r <= 1'b0;
            busy_r <= 1'b0;
        end else if (start) begin
            div_r  <= '0;
            bits_r <= len;
            tx_r   <= tx_data;
            sclk_r <= 1'b0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (tick_s) begin
                div_r <= '0;
                if (!sclk_r) begin
                    sclk_r <= 1'b1;
                    rx_r   <= {rx_r[30:0], miso};
                end else begin
                    sclk_r <= 1'b0;
                    tx_r   <= {tx_r[30:0], 1'b0};
                    bits_r <= bits_r - 6'd1;
                    busy_r <= (bits_r != 6'd1);
                end
            end else begin
                div_r <= div_r + DW'(1);
            end
        end
    end

endmodule

// File: rtl/caravel_spiflash.sv
// Wishbone-to-SPI flash read bridge: wakes the flash after reset, then serves
// 32-bit reads with 0x03 frames, streaming sequential words while CS stays low.
module caravel_spiflash
    import caravel_spiflash_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int CLK_DIV    = 1,
    parameter bit STREAM     = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);
    state_t                state_r, state_n;
    logic                  cs_r, cs_n;
    logic                  ack_r, ack_n;
    logic [31:0]           dat_r;
    logic [ADDR_WIDTH-1:0] addr_r, last_r, req_addr;
    logic [2:0]            gap_cnt_r;
    logic                  dat_ld, addr_ld, last_ld;
    logic                  sh_start, sh_done;
    logic [5:0]            sh_len;
    logic [31:0]           sh_tx, sh_rx;
    logic                  req_rd, req_wr, seq_hit;
    logic                  unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_dat_i, wb_adr_i};

    // The ack guard keeps a still-asserted strobe from being taken twice.
    assign req_rd   = wb_cyc_i && wb_stb_i && !wb_we_i && !ack_r;
    assign req_wr   = wb_cyc_i && wb_stb_i && wb_we_i && !ack_r;
    assign req_addr = {wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
    assign seq_hit  = STREAM && !cs_r && (req_addr == last_r + ADDR_WIDTH'(4));

    spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .start   (sh_start),
        .len     (sh_len),
        .tx_data (sh_tx),
        .miso    (flash_io1),
        .sclk    (flash_clk),
        .mosi    (flash_io0),
        .done    (sh_done),
        .rx_data (sh_rx)
    );

    // Next-state and frame sequencing; CS high in WAKE means the wake frame is not yet sent.
    always_comb begin
        state_n  = state_r;
        cs_n     = cs_r;
        ack_n    = 1'b0;
        sh_start = 1'b0;
        sh_len   = 6'd0;
        sh_tx    = 32'h0000_0000;
        dat_ld   = 1'b0;
        addr_ld  = 1'b0;
        last_ld  = 1'b0;
        case (state_r)
            ST_WAKE: begin
                if (cs_r) begin
                    sh_start = 1'b1;
                    sh_len   = 6'd8;
                    sh_tx    = {CMD_WAKE, 24'h00_0000};
                    cs_n     = 1'b0;
                end else if (sh_done) begin
                    state_n = ST_GAP;
                    cs_n    = 1'b1;
                end else begin
                    state_n = ST_WAKE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LEN - 3'd1) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_IDLE: begin
                if (req_wr) begin
                    ack_n = 1'b1;
                    cs_n  = STREAM ? 1'b1 : cs_r;
                end else if (req_rd && seq_hit) begin
                    state_n  = ST_DATA;
                    sh_start = 1'b1;
                    sh_len   = 6'd32;
                    addr_ld  = 1'b1;
                end else if (req_rd && !cs_r) begin
                    cs_n = 1'b1;
                end else if (req_rd) begin
                    state_n  = ST_CMD;
                    sh_start = 1'b1;
                    sh_len   = 6'd8;
                    sh_tx    = {CMD_READ, 24'h00_0000};
                    cs_n     = 1'b0;
                    addr_ld  = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (sh_done) begin
                    state_n  = ST_ADDR;
                    sh_start = 1'b1;
                    sh_len   = 6'(ADDR_WIDTH);
                    sh_tx    = 32'(addr_r) << (32 - ADDR_WIDTH);
                end else begin
                    state_n = ST_CMD;
                end
            end
            ST_ADDR: begin
                if (sh_done) begin
                    state_n  = ST_DATA;
                    sh_start = 1'b1;
                    sh_len   = 6'd32;
                end else begin
                    state_n = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (sh_done) begin
                    state_n = ST_ACK;
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_ACK: begin
                state_n = ST_IDLE;
                ack_n   = 1'b1;
                dat_ld  = 1'b1;
                last_ld = 1'b1;
                cs_n    = STREAM ? 1'b0 : 1'b1;
            end
            default: begin
                state_n = ST_WAKE;
                cs_n    = 1'b1;
            end
        endcase
    end

    // Controller state and registered bus/flash-select outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= ST_WAKE;
            cs_r      <= 1'b1;
            ack_r     <= 1'b0;
            dat_r     <= 32'h0000_0000;
            addr_r    <= '0;
            last_r    <= '0;
            gap_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_n;
            cs_r      <= cs_n;
            ack_r     <= ack_n;
            gap_cnt_r <= (state_r == ST_GAP) ? gap_cnt_r + 3'd1 : 3'd0;
            if (dat_ld) dat_r <= bswap32(sh_rx);
            if (addr_ld) addr_r <= req_addr;
            if (last_ld) last_r <= addr_r;
        end
    end

    assign wb_ack_o  = ack_r;
    assign wb_dat_o  = dat_r;
    assign flash_csb = cs_r;

endmodule

// File: tb/tb_caravel_spiflash.sv
// Directed bench for caravel_spiflash with a behavioural SPI flash model
// that decodes the MOSI frames and serves a small fixed byte image.
module tb_caravel_spiflash;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic        cyc  = 1'b0;
    logic        stb  = 1'b0;
    logic        we   = 1'b0;
    logic [3:0]  sel  = 4'hF;
    logic [31:0] adr  = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        csb, fclk, io0;
    logic        miso = 1'b0;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    caravel_spiflash #(.ADDR_WIDTH(24), .CLK_DIV(1), .STREAM(1'b1)) dut (
        .wb_clk_i (clk),  .wb_rst_i (rst),
        .wb_cyc_i (cyc),  .wb_stb_i (stb),  .wb_we_i (we),
        .wb_sel_i (sel),  .wb_adr_i (adr),  .wb_dat_i (wdat),
        .wb_ack_o (ack),  .wb_dat_o (rdat),
        .flash_csb(csb),  .flash_clk(fclk), .flash_io0(io0), .flash_io1(miso)
    );

    // Flash image
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h6F;  24'h000001: return 8'h00;
            24'h000002: return 8'h00;  24'h000003: return 8'h0B;
            24'h000004: return 8'h13;  24'h000005: return 8'h05;
            24'h000006: return 8'hA0;  24'h000007: return 8'h01;
            24'h000100: return 8'hDE;  24'h000101: return 8'hAD;
            24'h000102: return 8'hBE;  24'h000103: return 8'hEF;
            24'h000104: return 8'h11;  24'h000105: return 8'h22;
            24'h000106: return 8'h33;  24'h000107: return 8'h44;
            24'h000200: return 8'hA5;  24'h000201: return 8'h5A;
            24'h000202: return 8'hC3;  24'h000203: return 8'h3C;
            24'hFFFFFC: return 8'h01;  24'hFFFFFD: return 8'h02;
            24'hFFFFFE: return 8'h03;  24'hFFFFFF: return 8'h04;
            default:    return 8'hFF;
        endcase
    endfunction

    // Flash model: per-frame log of opcode, address and clock count
    int          frame_no = 0, fbits = 0, dcnt = 0, io0_err = 0, cur = 0;
    logic [7:0]  f_cmd  [16];
    logic [23:0] f_addr [16];
    int          f_bits [16];
    logic [23:0] m_ba;
    logic [7:0]  m_b;

    always @(negedge csb) begin
        frame_no++;
        cur   = (frame_no < 16) ? frame_no : 15;
        fbits = 0;
        dcnt  = 0;
        miso  = 1'b0;
        f_cmd[cur]  = 8'h00;
        f_addr[cur] = 24'h0;
        f_bits[cur] = 0;
    end

    always @(posedge fclk) begin
        if (csb === 1'b0) begin
            if (fbits < 8) f_cmd[cur] = {f_cmd[cur][6:0], io0};
            else if (fbits < 32) f_addr[cur] = {f_addr[cur][22:0], io0};
            else begin
                dcnt++;
                if (io0 !== 1'b0) io0_err++;
            end
            fbits++;
            f_bits[cur] = fbits;
        end
    end

    always @(negedge fclk) begin
        if (csb === 1'b0 && fbits >= 32 && f_cmd[cur] == 8'h03) begin
            m_ba = f_addr[cur] + 24'(dcnt / 8);
            m_b  = flash_byte(m_ba);
            miso = m_b[7 - (dcnt % 8)];
        end
    end

    // Bus/pin monitor
    int   ack_cnt = 0, dbl_cnt = 0, hi_run = 0, last_hi = 0;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            ack_cnt++;
            if (prev_ack) dbl_cnt++;
        end
        prev_ack = (ack === 1'b1);
        if (csb === 1'b1) hi_run++;
        else begin
            if (hi_run != 0) last_hi = hi_run;
            hi_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, output int n);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) break;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    int n, fb, fr0, ack_before;

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_csb", 32'(csb), 32'd1);
        chk("rst_clk", 32'(fclk), 32'd0);
        chk("rst_io0", 32'(io0), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'h0);
        fb = frame_no;
        rst = 1'b0;

        // Wake frame after reset release
        repeat (40) @(negedge clk);
        chk("wake_frames", 32'(frame_no - fb), 32'd1);
        chk("wake_cmd", 32'(f_cmd[fb + 1]), 32'hAB);
        chk("wake_bits", 32'(f_bits[fb + 1]), 32'd8);
        chk("wake_noack", 32'(ack_cnt), 32'd0);
        chk("wake_csb", 32'(csb), 32'd1);

        // Read 0x000000
        do_req(1'b0, 32'h0000_0000, n);
        chk("rd0_ack", 32'(ack), 32'd1);
        chk("rd0_lat", 32'(n), 32'd130);
        chk("rd0_dat", rdat, 32'h0B00_006F);
        chk("rd0_cmd", 32'(f_cmd[fb + 2]), 32'h03);
        chk("rd0_addr", 32'(f_addr[fb + 2]), 32'h0);
        chk("rd0_bits", 32'(f_bits[fb + 2]), 32'd64);
        chk("rd0_gap", 32'(last_hi >= 4), 32'd1);
        chk("rd0_csb", 32'(csb), 32'd0);
        chk("rd0_clk", 32'(fclk), 32'd0);

        // Streamed read 0x000004
        do_req(1'b0, 32'h0000_0004, n);
        chk("rd4_lat", 32'(n), 32'd66);
        chk("rd4_dat", rdat, 32'h01A0_0513);
        chk("rd4_frames", 32'(frame_no - fb), 32'd2);
        chk("rd4_bits", 32'(f_bits[fb + 2]), 32'd96);

        // Non-sequential read 0x000100
        do_req(1'b0, 32'h0000_0100, n);
        chk("rd100_ack", 32'(ack), 32'd1);
        chk("rd100_dat", rdat, 32'hEFBE_ADDE);
        chk("rd100_frames", 32'(frame_no - fb), 32'd3);
        chk("rd100_cmd", 32'(f_cmd[fb + 3]), 32'h03);
        chk("rd100_addr", 32'(f_addr[fb + 3]), 32'h000100);
        chk("rd100_cspulse", 32'(last_hi >= 1), 32'd1);

        // Write: immediate ack, stream ends, no flash traffic
        do_req(1'b1, 32'h0000_0104, n);
        chk("wr_lat", 32'(n), 32'd1);
        chk("wr_csb", 32'(csb), 32'd1);
        chk("wr_clk", 32'(fclk), 32'd0);
        chk("wr_io0", 32'(io0), 32'd0);
        chk("wr_frames", 32'(frame_no - fb), 32'd3);

        // Read last_addr+4 after write re-issues the command
        do_req(1'b0, 32'h0000_0104, n);
        chk("rd104_lat", 32'(n), 32'd130);
        chk("rd104_dat", rdat, 32'h4433_2211);
        chk("rd104_frames", 32'(frame_no - fb), 32'd4);
        chk("rd104_addr", 32'(f_addr[fb + 4]), 32'h000104);

        // Top of flash, then wrapped sequential read
        do_req(1'b0, 32'h00FF_FFFC, n);
        chk("rdtop_dat", rdat, 32'h0403_0201);
        chk("rdtop_addr", 32'(f_addr[fb + 5]), 32'hFFFFFC);
        do_req(1'b0, 32'h0000_0000, n);
        chk("rdwrap_lat", 32'(n), 32'd66);
        chk("rdwrap_dat", rdat, 32'h0B00_006F);
        chk("rdwrap_frames", 32'(frame_no - fb), 32'd5);

        // Reset during the address phase
        fr0 = frame_no;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0200;
        for (int i = 0; i < 500; i++) begin
            if (frame_no == fr0 + 1 && fbits >= 12) break;
            @(negedge clk);
        end
        chk("abort_inaddr", 32'(frame_no == fr0 + 1 && fbits >= 12 && fbits < 32), 32'd1);
        ack_before = ack_cnt;
        rst = 1'b1;
        #1;
        chk("abort_csb", 32'(csb), 32'd1);
        chk("abort_clk", 32'(fclk), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (ack === 1'b1) break;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("rearm_ack", 32'(ack), 32'd1);
        chk("rearm_dat", rdat, 32'h3CC3_5AA5);
        chk("rearm_frames", 32'(frame_no - fr0), 32'd3);
        chk("rearm_wakecmd", 32'(f_cmd[fr0 + 2]), 32'hAB);
        chk("rearm_wakebits", 32'(f_bits[fr0 + 2]), 32'd8);
        chk("rearm_rdaddr", 32'(f_addr[fr0 + 3]), 32'h000200);
        chk("rearm_gap", 32'(last_hi >= 4), 32'd1);
        @(negedge clk);
        chk("abort_noack", 32'(ack_cnt - ack_before), 32'd1);

        // Global properties
        repeat (4) @(negedge clk);
        chk("no_double_ack", 32'(dbl_cnt), 32'd0);
        chk("io0_low_in_data", 32'(io0_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/caravel_spiflash.md
# caravel_spiflash

Memory-mapped SPI flash read controller for the Caravel management SoC. It serves Wishbone read requests by fetching 32-bit words from the external boot flash over single-bit SPI (mode 0). The CPU executes its boot firmware directly through this block. It sits between the management Wishbone bus and the chip-level flash pins.

## Interface
- Clocking/reset (already decided): one clock; reset is asynchronous and active-high.

Parameters:
- `ADDR_WIDTH`, default 24: flash byte-address width sent on the wire.
- `CLK_DIV`, default 1: SPI clock half-period in `wb_clk_i` cycles; must be ≥1.
- `STREAM`, default 1: enables continuous sequential reads without re-issuing the command.

Ports:
- `wb_clk_i` in 1: system clock.
- `wb_rst_i` in 1: asynchronous active-high reset.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1: Wishbone classic request.
- `wb_sel_i` in 4: byte selects; ignored for reads.
- `wb_adr_i` in 32: byte address; bits [ADDR_WIDTH-1:2] are used.
- `wb_dat_i` in 32: write data; ignored.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `wb_dat_o` out 32: read data.
- `flash_csb` out 1: chip select, active low.
- `flash_clk` out 1: SPI clock, idle low.
- `flash_io0` out 1: MOSI.
- `flash_io1` in 1: MISO.

## Operation
- **Reset values:** `flash_csb`=1, `flash_clk`=0, `flash_io0`=0, `wb_ack_o`=0, `wb_dat_o`=0. State = WAKE.
- **WAKE:** after reset, send command 0xAB (release power-down), 8 SPI clocks, MSB first. Then raise CS and hold it high for ≥4 `wb_clk_i` cycles (GAP), then go to IDLE. Requests arriving during WAKE/GAP are held unacknowledged until IDLE.
- **IDLE:** a read is `cyc&stb&!we`. Flash address A = {wb_adr_i[ADDR_WIDTH-1:2], 2'b00}.
  - If STREAM=1, CS is still low, and A == last_addr+4: go straight to DATA.
  - Otherwise: if CS is low, raise it for one gap cycle; then go to CMD.
- **CMD:** CS low; shift 0x03 MSB first over 8 SPI clocks.
- **ADDR:** shift A, ADDR_WIDTH bits, MSB first.
- **DATA:** sample 32 bits on `flash_io1`. Byte k (k=0..3) arrives MSB first and is stored in `wb_dat_o[8k+7:8k]`, so the result is little-endian. `flash_io0` is driven 0.
- **ACK:**
  - Assert `wb_ack_o` for one cycle with `wb_dat_o` valid and set last_addr=A.
  - With STREAM=1, keep CS low and `flash_clk` low; otherwise raise CS.
  - Return to IDLE.
- **Writes** (`cyc&stb&we`) in IDLE:
  - Acknowledge on the next cycle; no flash traffic; data discarded.
  - With STREAM=1, a write also raises CS, ending the stream.
- **Reset mid-transaction:** CS rises and clk falls immediately. No ack is issued for the aborted request. The block restarts at WAKE.
- **Wrap:** last_addr+4 wraps modulo 2^ADDR_WIDTH. A wrapped address is still treated as sequential.

## Timing
- SPI mode 0: `flash_io0` changes only while `flash_clk` is low (falling edge or CS fall); `flash_io1` is sampled on the `wb_clk_i` edge that raises `flash_clk`.
- Each SPI bit takes 2·CLK_DIV cycles.
- First MOSI bit is valid in the cycle CS falls; the first rising edge follows CLK_DIV cycles later.
- Non-stream read, ADDR_WIDTH=24: 64 SPI clocks. `wb_ack_o` rises exactly 2 + 128·CLK_DIV cycles after the accepting cycle (default CLK_DIV: 130).
- Streamed read: 32 SPI clocks; ack at 2 + 64·CLK_DIV cycles (default: 66).
- `wb_ack_o` is never high for two consecutive cycles. A new request is accepted no earlier than the cycle after ack.

## Structure
- Shared package `caravel_spiflash_pkg`: state enum (WAKE, GAP, IDLE, CMD, ADDR, DATA, ACK), command constants CMD_WAKE=8'hAB and CMD_READ=8'h03, gap length constant.
- One natural sub-module, `spi_shifter`: clock divider plus 32-bit shift-out/shift-in engine with a bit counter, driven by the top FSM with length and data.

## Test plan
- **Reset release:** first CS-low frame carries exactly 0xAB over 8 clocks; CS then stays high ≥4 cycles; no ack is issued.
- **Read byte address 0x000000:** flash holds bytes 6F,00,00,0B → `wb_dat_o`=0x0B00006F.
  - MOSI shows 0x03 then 0x000000.
  - Ack arrives 130 cycles after the request (CLK_DIV=1).
- **Sequential read 0x000004 after 0x000000 (STREAM=1):** no command or address bits; ack in 66 cycles; correct next word.
- **Non-sequential read 0x000100 after 0x000004:** CS pulses high ≥1 cycle, then the full 0x03 + 0x000100 frame is sent.
- **Write to any address:** ack the next cycle; flash pins idle; the following read to last_addr+4 re-issues the command.
- **Reset during ADDR phase:** CS high and clk low immediately; no ack; the WAKE frame repeats; a subsequent read returns correct data.
